// File: rtl/riscv_clint_mmio_pkg.sv
// -----------------------------------------------------------------------------
// riscv_clint_mmio_pkg
//   Shared definitions for the CLINT MMIO responder: bus width, register
//   offsets inside the CLINT window, response FSM state encoding, register
//   selector enum and two small helpers (offset decode, byte-strobe merge).
// -----------------------------------------------------------------------------
package riscv_clint_mmio_pkg;

   localparam int unsigned DATA_WIDTH = 32;

   // Offsets inside the 64 KiB CLINT window
   localparam logic [15:0] CLINT_MSIP        = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
   localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
   localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
   localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

   typedef enum logic {
      CLINT_ST_IDLE = 1'b0,
      CLINT_ST_RESP = 1'b1
   } clint_state_e;

   typedef enum logic [2:0] {
      REG_MSIP,
      REG_MTIMECMP_LO,
      REG_MTIMECMP_HI,
      REG_MTIME_LO,
      REG_MTIME_HI,
      REG_NONE
   } clint_reg_e;

   function automatic clint_reg_e decode_offset(input logic [15:0] off);
      case (off)
         CLINT_MSIP:        return REG_MSIP;
         CLINT_MTIMECMP_LO: return REG_MTIMECMP_LO;
         CLINT_MTIMECMP_HI: return REG_MTIMECMP_HI;
         CLINT_MTIME_LO:    return REG_MTIME_LO;
         CLINT_MTIME_HI:    return REG_MTIME_HI;
         default:           return REG_NONE;
      endcase
   endfunction

   // Replace only the bytes whose strobe is set
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/riscv_clint_timer.sv
// -----------------------------------------------------------------------------
// riscv_clint_timer
//   Prescaler plus free-running 64-bit mtime counter.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     wr_en_i       load mtime with wr_data_i this cycle (beats a tick)
//     wr_data_i     full 64-bit value to load (caller merges halves/bytes)
//     mtime_o       current mtime register
//     mtime_d_o     next-state mtime (used for the registered compare)
// -----------------------------------------------------------------------------
module riscv_clint_timer #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en_i,
   input  logic [63:0] wr_data_i,
   output logic [63:0] mtime_o,
   output logic [63:0] mtime_d_o
);

   localparam int unsigned     PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [63:0]   mtime_q, mtime_d;
   logic          tick;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      tick    = (presc_q == PRESC_MAX);
      presc_d = tick ? '0 : presc_q + 1'b1;
      mtime_d = mtime_q;
      // A software write wins over a coincident tick; the prescaler wraps regardless.
      if (wr_en_i) begin
         mtime_d = wr_data_i;
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         presc_q <= '0;
         mtime_q <= '0;
      end else begin
         presc_q <= presc_d;
         mtime_q <= mtime_d;
      end
   end

   assign mtime_o   = mtime_q;
   assign mtime_d_o = mtime_d;

endmodule

// File: rtl/riscv_clint_mmio.sv
// -----------------------------------------------------------------------------
// riscv_clint_mmio
//   Memory-mapped CLINT responder: msip, mtimecmp and the 64-bit mtime behind a
//   valid/ready request/response channel, plus level timer/software interrupts.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     req_valid/req_ready           request handshake (ready only when idle)
//     req_we/req_addr/req_wdata/req_wstrb  request payload
//     rsp_valid/rsp_ready           response handshake (held until accepted)
//     rsp_rdata/rsp_err             read data (0 on writes/errors), error flag
//     timer_irq                     registered (mtime >= mtimecmp)
//     soft_irq                      msip[0]
// -----------------------------------------------------------------------------
module riscv_clint_mmio
   import riscv_clint_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [3:0]            req_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  timer_irq,
   output logic                  soft_irq
);

   clint_state_e state_q;
   logic         rsp_valid_q, rsp_err_q, timer_irq_q, msip_q, msip_d;
   logic [31:0]  rsp_rdata_q, rd_val;
   logic [63:0]  mtimecmp_q, mtimecmp_d;
   logic [63:0]  mtime_q, mtime_d, mtime_wdata;
   logic         mtime_we;
   logic         accept, addr_hit, wr_hit;
   clint_reg_e   reg_sel;

   assign req_ready = (state_q == CLINT_ST_IDLE);
   assign accept    = req_valid && req_ready;

   // Address decode: only the low 16 bits select a register, and only inside our window
   always_comb begin
      reg_sel  = decode_offset(req_addr[15:0]);
      addr_hit = (req_addr[31:16] == BASE_ADDR[31:16]) &&
                 (req_addr[1:0] == 2'b00) &&
                 (reg_sel != REG_NONE);
   end

   always_comb begin
      rd_val = '0;
      case (reg_sel)
         REG_MSIP:        rd_val = {31'd0, msip_q};
         REG_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
         REG_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
         REG_MTIME_LO:    rd_val = mtime_q[31:0];
         REG_MTIME_HI:    rd_val = mtime_q[63:32];
         default:         rd_val = '0;
      endcase
   end

   assign wr_hit = accept && req_we && addr_hit;

   // Next-state for software-visible registers; halves are written independently (no carry)
   always_comb begin
      msip_d      = msip_q;
      mtimecmp_d  = mtimecmp_q;
      mtime_we    = 1'b0;
      mtime_wdata = mtime_q;
      if (wr_hit) begin
         case (reg_sel)
            REG_MSIP:        if (req_wstrb[0]) msip_d = req_wdata[0];
            REG_MTIMECMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  req_wdata, req_wstrb);
            REG_MTIMECMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], req_wdata, req_wstrb);
            REG_MTIME_LO: begin
               // An all-zero strobe must not steal a tick from the counter
               mtime_we          = |req_wstrb;
               mtime_wdata[31:0] = merge_bytes(mtime_q[31:0], req_wdata, req_wstrb);
            end
            REG_MTIME_HI: begin
               mtime_we           = |req_wstrb;
               mtime_wdata[63:32] = merge_bytes(mtime_q[63:32], req_wdata, req_wstrb);
            end
            default: ;
         endcase
      end
   end

   riscv_clint_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (mtime_we),
      .wr_data_i (mtime_wdata),
      .mtime_o   (mtime_q),
      .mtime_d_o (mtime_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLINT_ST_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         msip_q      <= 1'b0;
         mtimecmp_q  <= '1;
         timer_irq_q <= 1'b0;
      end else begin
         msip_q      <= msip_d;
         mtimecmp_q  <= mtimecmp_d;
         // Compare next-state values so a mtimecmp write shows up one cycle after accept
         timer_irq_q <= (mtime_d >= mtimecmp_d);
         case (state_q)
            CLINT_ST_IDLE: begin
               if (accept) begin
                  state_q     <= CLINT_ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= !addr_hit;
                  rsp_rdata_q <= (req_we || !addr_hit) ? '0 : rd_val;
               end
            end
            CLINT_ST_RESP: begin
               if (rsp_ready) begin
                  state_q     <= CLINT_ST_IDLE;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: state_q <= CLINT_ST_IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign timer_irq = timer_irq_q;
   assign soft_irq  = msip_q;

endmodule

// File: tb/tb_riscv_clint_mmio.sv
module tb_riscv_clint_mmio;

   localparam logic [31:0] B = 32'h0200_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic        rsp_ready = 1'b0;
   logic        req_ready, rsp_valid, rsp_err, timer_irq, soft_irq;
   logic [31:0] rsp_rdata;

   int vectors = 0;
   int miscompares = 0;
   int edge_cnt = 0;   // posedges since reset release; mtime ticks when this is a multiple of 4

   riscv_clint_mmio #(
      .BASE_ADDR (B),
      .TICK_DIV  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .timer_irq (timer_irq),
      .soft_irq  (soft_irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) edge_cnt <= 0;
      else     edge_cnt <= edge_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction starting at a negedge; accept on the next posedge,
   // response sampled at the following negedge, consumed on the next posedge.
   task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                       output logic irq);
      int n = 0;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
      rsp_ready = 1'b1;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_before_accept", req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("rsp_valid_latency", rsp_valid, 1);
      rdata = rsp_rdata; err = rsp_err; irq = timer_irq;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rd(input string tag, input logic [31:0] addr,
                     input logic [31:0] exp_d, input logic exp_e);
      logic [31:0] d; logic e; logic i;
      xact(1'b0, addr, 32'h0, 4'h0, d, e, i);
      check({tag, "_rdata"}, d, exp_d);
      check({tag, "_err"}, e, exp_e);
   endtask

   task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic exp_e);
      logic [31:0] d; logic e; logic i;
      xact(1'b1, addr, data, strb, d, e, i);
      check({tag, "_rdata"}, d, 32'h0);
      check({tag, "_err"}, e, exp_e);
   endtask

   initial begin
      logic [31:0] d; logic e; logic irq;
      int n;

      // 1: reset state, then 40 idle cycles at TICK_DIV=4 -> mtime = 10
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_timer_irq", timer_irq, 0);
      check("rst_soft_irq", soft_irq, 0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      rd("mtime_lo_40cyc", B | 32'hBFF8, 32'd10, 1'b0);
      rd("mtime_hi_40cyc", B | 32'hBFFC, 32'd0, 1'b0);

      // 2: mtimecmp = 0x20 (hi first); irq rises on the edge mtime becomes 0x20 (edge 128)
      wr("cmp_hi_0", B | 32'h4004, 32'h0, 4'hF, 1'b0);
      check("irq_low_cmp_ffffffff", timer_irq, 0);
      wr("cmp_lo_20", B | 32'h4000, 32'h20, 4'hF, 1'b0);
      n = 0;
      while (!timer_irq && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("irq_rise_edge", edge_cnt, 128);
      check("irq_high", timer_irq, 1);
      xact(1'b1, B | 32'h4004, 32'hFFFF_FFFF, 4'hF, d, e, irq);
      check("irq_low_after_cmp_hi_write", irq, 0);

      // 3: mtime = all ones, lo write lands on a tick edge (tick dropped), then wraps to 0
      wr("mtime_hi_ones", B | 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0);
      n = 0;
      while ((edge_cnt + 1) % 4 != 0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      wr("mtime_lo_ones", B | 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0);
      rd("mtime_lo_pre_wrap", B | 32'hBFF8, 32'hFFFF_FFFF, 1'b0);
      rd("mtime_hi_pre_wrap", B | 32'hBFFC, 32'hFFFF_FFFF, 1'b0);
      rd("mtime_lo_wrapped", B | 32'hBFF8, 32'h0, 1'b0);
      rd("mtime_hi_wrapped", B | 32'hBFFC, 32'h0, 1'b0);

      // 4: msip bit0 only, strobe-gated
      wr("msip_set", B, 32'hFFFF_FFFF, 4'b0001, 1'b0);
      check("soft_irq_set", soft_irq, 1);
      rd("msip_read1", B, 32'h1, 1'b0);
      wr("msip_nostrb", B, 32'h0, 4'b0000, 1'b0);
      check("soft_irq_nostrb", soft_irq, 1);
      wr("msip_hibytes", B, 32'h0, 4'b1110, 1'b0);
      check("soft_irq_hibytes", soft_irq, 1);
      wr("msip_clear", B, 32'h0, 4'b0001, 1'b0);
      check("soft_irq_clear", soft_irq, 0);
      rd("msip_read0", B, 32'h0, 1'b0);
      wr("msip_set2", B, 32'h1, 4'b0001, 1'b0);

      // 5: errors leave state untouched
      rd("err_unmapped", B | 32'h0008, 32'h0, 1'b1);
      rd("err_misaligned", B | 32'h4002, 32'h0, 1'b1);
      rd("err_base", 32'h0300_4000, 32'h0, 1'b1);
      wr("err_wr_misaligned", B | 32'h4002, 32'h0, 4'hF, 1'b1);
      wr("err_wr_base", 32'h0300_0000, 32'h0, 4'b0001, 1'b1);
      check("soft_irq_after_err", soft_irq, 1);
      rd("cmp_lo_intact", B | 32'h4000, 32'h20, 1'b0);
      rd("cmp_hi_intact", B | 32'h4004, 32'hFFFF_FFFF, 1'b0);

      // 6: backpressure, queued second request, reset during RESP
      req_valid = 1'b1; req_we = 1'b0; req_addr = B | 32'h4000; req_wstrb = 4'h0;
      rsp_ready = 1'b0;
      check("bp_ready_idle", req_ready, 1);
      @(negedge clk);
      req_addr = B | 32'h4004;
      for (int i = 0; i < 5; i++) begin
         check("bp_req_ready", req_ready, 0);
         check("bp_rsp_valid", rsp_valid, 1);
         check("bp_rsp_rdata", rsp_rdata, 32'h20);
         check("bp_rsp_err", rsp_err, 0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp_released_valid", rsp_valid, 0);
      check("bp_released_ready", req_ready, 1);
      @(negedge clk);
      check("bp_second_valid", rsp_valid, 1);
      check("bp_second_rdata", rsp_rdata, 32'hFFFF_FFFF);
      req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_rsp_valid", rsp_valid, 0);
      check("rst_mid_req_ready", req_ready, 1);
      check("rst_mid_soft_irq", soft_irq, 0);
      check("rst_mid_timer_irq", timer_irq, 0);
      rst = 1'b0;
      rd("post_rst_mtime_lo", B | 32'hBFF8, 32'h0, 1'b0);
      rd("post_rst_cmp_hi", B | 32'h4004, 32'hFFFF_FFFF, 1'b0);
      rd("post_rst_msip", B, 32'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
